revela_papeis: RTL and testbench

//  Reads the 10-bit game word (jogo_atual) from the seed path and reveals each player's role in turn on one display.

---
 rtl/revela_papeis_if.sv | 30 +++
 rtl/revela_papeis.sv | 149 ++++++++++++++
 tb/tb_revela_papeis.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/revela_papeis_if.sv
// Bundle between unidade_controle (master) and revela_papeis (slave):
// reveal-sequence controls and game word in, display/status/index results out.
interface revela_papeis_if #(
   parameter int N_JOG = 5
);
   logic                 inicia;
   logic                 botao;
   logic                 passa;
   logic [2*N_JOG-1:0]   jogo_atual;
   logic [2:0]           jogador_atual;
   logic [1:0]           papel;
   logic                 mostrando;
   logic [2:0]           lobo_idx;
   logic [2:0]           medico_idx;
   logic                 pronto;
   logic                 erro_jogo;
   logic [3:0]           db_estado;

   modport master (
      output inicia, botao, passa, jogo_atual,
      input  jogador_atual, papel, mostrando, lobo_idx, medico_idx,
             pronto, erro_jogo, db_estado
   );

   modport slave (
      input  inicia, botao, passa, jogo_atual,
      output jogador_atual, papel, mostrando, lobo_idx, medico_idx,
             pronto, erro_jogo, db_estado
   );
endinterface

// File: rtl/revela_papeis.sv
// Captures and validates the game word, then walks every player through
// reveal (botao) / hide (passa or timeout) on a single shared display.
module revela_papeis #(
   parameter int N_JOG   = 5,
   parameter int T_EXIBE = 50_000_000
) (
   input  logic            clock,
   input  logic            reset,
   revela_papeis_if.slave  bus
);
   localparam logic [3:0] OCIOSO    = 4'd0;
   localparam logic [3:0] CAPTURA   = 4'd1;
   localparam logic [3:0] VALIDA    = 4'd2;
   localparam logic [3:0] AGUARDA   = 4'd3;
   localparam logic [3:0] MOSTRA    = 4'd4;
   localparam logic [3:0] PROXIMO   = 4'd5;
   localparam logic [3:0] CONCLUIDO = 4'd6;
   localparam logic [3:0] ERRO      = 4'd15;

   localparam int          TW     = (T_EXIBE > 2) ? $clog2(T_EXIBE) : 1;
   localparam logic [TW-1:0] T_MAX  = TW'(T_EXIBE - 1);
   localparam logic [2:0]  ULTIMO = 3'(N_JOG - 1);

   logic [3:0]           estado_q, estado_d;
   logic [2*N_JOG-1:0]   jogo_q, jogo_d;
   logic [2:0]           jog_q, jog_d;
   logic [2:0]           lobo_q, lobo_d;
   logic [2:0]           medico_q, medico_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [1:0]           botao_q, passa_q;

   logic                 botao_pulso, passa_pulso;
   logic [1:0]           campo [N_JOG];
   logic [3:0]           n_lobo, n_medico;
   logic                 tem_invalido, valido;
   logic [2:0]           pos_lobo, pos_medico;

   // Player 0 occupies the most significant field of the word.
   for (genvar gi = 0; gi < N_JOG; gi++) begin : g_campo
      assign campo[gi] = jogo_q[2*(N_JOG-1-gi) +: 2];
   end

   assign botao_pulso = botao_q[0] & ~botao_q[1];
   assign passa_pulso = passa_q[0] & ~passa_q[1];

   always_comb begin
      n_lobo       = '0;
      n_medico     = '0;
      tem_invalido = 1'b0;
      pos_lobo     = '0;
      pos_medico   = '0;
      for (int i = 0; i < N_JOG; i++) begin
         case (campo[i])
            2'b01: begin
               n_lobo   = n_lobo + 4'd1;
               pos_lobo = 3'(i);
            end
            2'b10: begin
               n_medico   = n_medico + 4'd1;
               pos_medico = 3'(i);
            end
            2'b11:   tem_invalido = 1'b1;
            default: ;
         endcase
      end
      valido = (n_lobo == 4'd1) && (n_medico == 4'd1) && !tem_invalido;
   end

   always_comb begin
      estado_d = estado_q;
      jogo_d   = jogo_q;
      jog_d    = jog_q;
      lobo_d   = lobo_q;
      medico_d = medico_q;
      timer_d  = timer_q;
      case (estado_q)
         OCIOSO: if (bus.inicia) estado_d = CAPTURA;
         CAPTURA: begin
            jogo_d   = bus.jogo_atual;
            jog_d    = '0;
            lobo_d   = '0;
            medico_d = '0;
            estado_d = VALIDA;
         end
         VALIDA: begin
            if (valido) begin
               lobo_d   = pos_lobo;
               medico_d = pos_medico;
               estado_d = AGUARDA;
            end else begin
               estado_d = ERRO;
            end
         end
         AGUARDA: begin
            if (botao_pulso) begin
               timer_d  = '0;
               estado_d = MOSTRA;
            end
         end
         MOSTRA: begin
            timer_d = timer_q + 1'b1;
            if (passa_pulso || timer_q == T_MAX) estado_d = PROXIMO;
         end
         PROXIMO: begin
            if (jog_q == ULTIMO) begin
               estado_d = CONCLUIDO;
            end else begin
               jog_d    = jog_q + 3'd1;
               estado_d = AGUARDA;
            end
         end
         CONCLUIDO: if (bus.inicia) estado_d = CAPTURA;
         ERRO:      if (bus.inicia) estado_d = CAPTURA;
         default:   estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= OCIOSO;
         jogo_q   <= '0;
         jog_q    <= '0;
         lobo_q   <= '0;
         medico_q <= '0;
         timer_q  <= '0;
         botao_q  <= '0;
         passa_q  <= '0;
      end else begin
         estado_q <= estado_d;
         jogo_q   <= jogo_d;
         jog_q    <= jog_d;
         lobo_q   <= lobo_d;
         medico_q <= medico_d;
         timer_q  <= timer_d;
         botao_q  <= {botao_q[0], bus.botao};
         passa_q  <= {passa_q[0], bus.passa};
      end
   end

   // Outputs come only from registers or decoded state.
   assign bus.db_estado     = estado_q;
   assign bus.mostrando     = (estado_q == MOSTRA);
   assign bus.papel         = (estado_q == MOSTRA) ? campo[jog_q] : 2'b00;
   assign bus.jogador_atual = jog_q;
   assign bus.lobo_idx      = lobo_q;
   assign bus.medico_idx    = medico_q;
   assign bus.pronto        = (estado_q == CONCLUIDO);
   assign bus.erro_jogo     = (estado_q == ERRO);
endmodule

// File: tb/tb_revela_papeis.sv
// Directed bench for revela_papeis with a short display timeout (T_EXIBE=8).
module tb_revela_papeis;
   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;

   revela_papeis_if #(.N_JOG(5)) bus ();

   revela_papeis #(.N_JOG(5), .T_EXIBE(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One-cycle press, then one more edge so the FSM has acted on the pulse.
   task automatic press_botao();
      bus.botao = 1'b1;
      tick(1);
      bus.botao = 1'b0;
      tick(1);
   endtask

   task automatic press_passa();
      bus.passa = 1'b1;
      tick(1);
      bus.passa = 1'b0;
      tick(1);
   endtask

   // inicia -> CAPTURA -> VALIDA -> AGUARDA/ERRO
   task automatic start(input logic [9:0] word);
      bus.jogo_atual = word;
      bus.inicia = 1'b1;
      tick(1);
      bus.inicia = 1'b0;
      tick(2);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".db_estado"}, bus.db_estado, 0);
      chk({tag, ".mostrando"}, bus.mostrando, 0);
      chk({tag, ".papel"}, bus.papel, 0);
      chk({tag, ".jogador"}, bus.jogador_atual, 0);
      chk({tag, ".lobo"}, bus.lobo_idx, 0);
      chk({tag, ".medico"}, bus.medico_idx, 0);
      chk({tag, ".pronto"}, bus.pronto, 0);
      chk({tag, ".erro"}, bus.erro_jogo, 0);
   endtask

   logic [1:0] papeis1 [5];
   int         cnt;
   logic       prev;

   initial begin
      n_checks = 0;
      n_errors = 0;
      papeis1[0] = 2'b01; papeis1[1] = 2'b10; papeis1[2] = 2'b00;
      papeis1[3] = 2'b00; papeis1[4] = 2'b00;
      bus.inicia = 1'b0;
      bus.botao = 1'b0;
      bus.passa = 1'b0;
      bus.jogo_atual = '0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      chk_all_zero("reset");

      // 1: full walk-through of a valid word
      start(10'b01_10_00_00_00);
      chk("t1.db_aguarda", bus.db_estado, 3);
      chk("t1.lobo", bus.lobo_idx, 0);
      chk("t1.medico", bus.medico_idx, 1);
      for (int p = 0; p < 5; p++) begin
         chk($sformatf("t1.p%0d.jogador", p), bus.jogador_atual, p);
         press_botao();
         chk($sformatf("t1.p%0d.mostrando", p), bus.mostrando, 1);
         chk($sformatf("t1.p%0d.papel", p), bus.papel, papeis1[p]);
         press_passa();
         chk($sformatf("t1.p%0d.db_proximo", p), bus.db_estado, 5);
         chk($sformatf("t1.p%0d.papel_oculto", p), bus.papel, 0);
         tick(1);
      end
      chk("t1.pronto", bus.pronto, 1);
      chk("t1.db_concluido", bus.db_estado, 6);
      chk("t1.jogador_max", bus.jogador_atual, 4);

      // 2: invalid words
      start(10'b01_01_00_00_00);
      chk("t2a.erro", bus.erro_jogo, 1);
      chk("t2a.db", bus.db_estado, 15);
      chk("t2a.medico", bus.medico_idx, 0);
      chk("t2a.pronto", bus.pronto, 0);
      press_botao();
      chk("t2a.mostrando", bus.mostrando, 0);
      press_passa();
      chk("t2a.db_hold", bus.db_estado, 15);
      start(10'b11_10_00_00_01);
      chk("t2b.erro", bus.erro_jogo, 1);
      chk("t2b.db", bus.db_estado, 15);
      chk("t2b.lobo", bus.lobo_idx, 0);

      // 3: auto-hide after exactly T_EXIBE clocks
      start(10'b01_10_00_00_00);
      chk("t3.erro_clear", bus.erro_jogo, 0);
      chk("t3.db", bus.db_estado, 3);
      press_botao();
      cnt = 0;
      for (int k = 0; k < 20 && bus.mostrando; k++) begin
         cnt++;
         tick(1);
      end
      chk("t3.show_cycles", cnt, 8);
      chk("t3.db_proximo", bus.db_estado, 5);
      tick(1);
      chk("t3.jogador", bus.jogador_atual, 1);

      // 4: held button reveals once; same-cycle presses
      bus.botao = 1'b1;
      cnt = 0;
      prev = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         if (bus.mostrando && !prev) cnt++;
         prev = bus.mostrando;
      end
      bus.botao = 1'b0;
      tick(2);
      chk("t4.held_reveals", cnt, 1);
      chk("t4.held_jogador", bus.jogador_atual, 2);
      chk("t4.held_db", bus.db_estado, 3);
      bus.botao = 1'b1;
      bus.passa = 1'b1;
      tick(1);
      bus.botao = 1'b0;
      bus.passa = 1'b0;
      tick(1);
      chk("t4.both_aguarda", bus.db_estado, 4);
      bus.botao = 1'b1;
      bus.passa = 1'b1;
      tick(1);
      bus.botao = 1'b0;
      bus.passa = 1'b0;
      tick(1);
      chk("t4.both_mostra", bus.db_estado, 5);
      tick(1);
      chk("t4.jogador", bus.jogador_atual, 3);

      // 5: reset mid-reveal, then restart
      press_botao();
      chk("t5.db_mostra", bus.db_estado, 4);
      reset = 1'b1;
      tick(1);
      chk_all_zero("t5.reset");
      reset = 1'b0;
      tick(1);
      start(10'b01_10_00_00_00);
      chk("t5.restart_jogador", bus.jogador_atual, 0);
      press_botao();
      chk("t5.restart_papel", bus.papel, 2'b01);

      // 6: word changes after capture are ignored; new game from CONCLUIDO
      bus.jogo_atual = 10'b10_01_00_00_00;
      tick(1);
      chk("t6.papel_hold", bus.papel, 2'b01);
      press_passa();
      tick(1);
      chk("t6.lobo_hold", bus.lobo_idx, 0);
      chk("t6.medico_hold", bus.medico_idx, 1);
      press_botao();
      chk("t6.papel_p1", bus.papel, 2'b10);
      press_passa();
      tick(1);
      for (int p = 2; p < 5; p++) begin
         press_botao();
         press_passa();
         tick(1);
      end
      chk("t6.pronto", bus.pronto, 1);
      start(10'b00_00_00_10_01);
      chk("t6.new_lobo", bus.lobo_idx, 4);
      chk("t6.new_medico", bus.medico_idx, 3);
      chk("t6.new_pronto", bus.pronto, 0);
      chk("t6.new_jogador", bus.jogador_atual, 0);
      chk("t6.new_db", bus.db_estado, 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
